mem_stage_sram_ctrl: RTL and testbench

//   MEM-stage data-memory controller. It consumes the execute stage's outputs:
//   ALU_result is the byte address, Val_Rm is the store data, and MEM_R_EN / MEM_W_EN select the operation.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 23 ++
 rtl/mem_stage_sram_ctrl_phase_timer.sv | 27 ++
 rtl/mem_stage_sram_ctrl.sv | 110 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding,
// default memory base and SRAM geometry.
package mem_stage_sram_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int unsigned MEM_BASE_DEF = 1024;
  localparam int unsigned SRAM_AW      = 18;
  localparam int unsigned WIDX_W       = SRAM_AW - 1;
  localparam int unsigned CNT_W        = 4;

  // Halfword address of one half of a 32-bit word.
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [WIDX_W-1:0] widx,
                                                   input logic hi);
    return {widx, hi};
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_phase_timer.sv
// Per-phase wait counter: cleared by load, advanced by tick, flags the
// final cycle of a phase.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data memory controller: each 32-bit load/store becomes two
// timed 16-bit transfers on an asynchronous SRAM while the pipeline is frozen.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BASE    = MEM_BASE_DEF,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        Val_Rm,
  output logic               ready,
  output logic [31:0]        rd_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_t            state, state_next;
  logic              req;
  logic [31:0]       offset;
  logic [WIDX_W-1:0] widx_q;
  logic [31:0]       wdata_q;
  logic              store_q;
  logic              in_phase;
  logic              timer_load;
  logic [CNT_W-1:0]  count;
  logic              last;
  logic              unused_offset_bits;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = ALU_result - MEM_BASE;
  assign unused_offset_bits = ^{offset[31:WIDX_W+2], offset[1:0]};

  assign in_phase   = (state == ST_LO) || (state == ST_HI);
  assign timer_load = !in_phase || last;

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .tick  (in_phase),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req)  state_next = ST_LO;
      ST_LO:   if (last) state_next = ST_HI;
      ST_HI:   if (last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request is captured once; the frozen pipeline may change inputs later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      widx_q  <= offset[WIDX_W+1:2];
      wdata_q <= Val_Rm;
      store_q <= MEM_W_EN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!store_q && last) begin
      if (state == ST_LO) rd_data[15:0]  <= sram_rdata;
      if (state == ST_HI) rd_data[31:16] <= sram_rdata;
    end
  end

  always_comb begin
    ready      = (state == ST_DONE) || (state == ST_IDLE && !req);
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if (in_phase) begin
      sram_addr  = half_addr(widx_q, state == ST_HI);
      sram_wdata = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
      // Last cycle of a store phase releases WE to hold address/data.
      sram_we_n  = !(store_q && !last);
      sram_oe_n  = store_q;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: SRAM model, per-cycle expected
// schedule built from the access rules, plus literal spot checks.
module tb_mem_stage_sram_ctrl;

  localparam int W    = 3;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, Val_Rm;
  logic        ready;
  logic [31:0] rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = 16'h0;
  logic        sram_we_n, sram_oe_n;

  logic [15:0] sram [0:262143] = '{default: 16'h0};

  typedef struct {
    logic        ready, we_n, oe_n;
    logic        a_chk;
    logic [17:0] addr;
    logic        d_chk;
    logic [15:0] wdata;
    logic        r_chk;
    logic [31:0] rd;
  } exp_t;

  exp_t        sched[$];
  logic [15:0] model_mem [int];
  logic [31:0] model_rd;
  logic        chk_en;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_stage_sram_ctrl #(.MEM_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_result (ALU_result),
    .Val_Rm     (Val_Rm),
    .ready      (ready),
    .rd_data    (rd_data),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: writes while WE is low, drives data while OE is low.
  always @(negedge clk) begin
    if (!sram_we_n) sram[sram_addr] = sram_wdata;
    sram_rdata = sram_oe_n ? 16'h0 : sram[sram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    return model_mem.exists(a) ? model_mem[a] : 16'h0;
  endfunction

  // Drive a request and append its whole cycle-by-cycle expectation.
  task automatic start_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d);
    logic [31:0] widx;
    logic [17:0] lo;
    exp_t        e;
    MEM_R_EN = r; MEM_W_EN = w; ALU_result = a; Val_Rm = d;
    widx = (a - 32'(BASE)) >> 2;
    lo   = {widx[16:0], 1'b0};
    e = '{ready: 1'b0, we_n: 1'b1, oe_n: 1'b1, a_chk: 1'b0, addr: '0,
          d_chk: 1'b0, wdata: '0, r_chk: 1'b1, rd: model_rd};
    sched.push_back(e);
    for (int j = 1; j <= 2 * W; j++) begin
      int ph, c;
      ph = (j - 1) / W;
      c  = (j - 1) % W;
      e.ready = 1'b0;
      e.a_chk = 1'b1;
      e.addr  = lo + 18'(ph);
      e.we_n  = w ? (c == W - 1) : 1'b1;
      e.oe_n  = w;
      e.d_chk = w;
      e.wdata = (ph == 1) ? d[31:16] : d[15:0];
      e.r_chk = w;
      e.rd    = model_rd;
      sched.push_back(e);
    end
    if (w) begin
      model_mem[int'(lo)]         = d[15:0];
      model_mem[int'(lo | 18'd1)] = d[31:16];
    end else begin
      model_rd = {mem_rd(int'(lo | 18'd1)), mem_rd(int'(lo))};
    end
    e = '{ready: 1'b1, we_n: 1'b1, oe_n: 1'b1, a_chk: 1'b0, addr: '0,
          d_chk: 1'b0, wdata: '0, r_chk: 1'b1, rd: model_rd};
    sched.push_back(e);
  endtask

  task automatic wait_done();
    repeat (2 * W + 1) @(posedge clk) #1;
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    repeat (n) @(posedge clk) #1;
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b0; model_rd = '0;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = '0; Val_Rm = '0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          exp_t e;
          if (sched.size() > 0) begin
            e = sched.pop_front();
          end else begin
            e = '{ready: !(MEM_R_EN | MEM_W_EN), we_n: 1'b1, oe_n: 1'b1, a_chk: 1'b0,
                  addr: '0, d_chk: 1'b0, wdata: '0, r_chk: 1'b1, rd: model_rd};
          end
          chk("ready", 32'(ready), 32'(e.ready));
          chk("we_n", 32'(sram_we_n), 32'(e.we_n));
          chk("oe_n", 32'(sram_oe_n), 32'(e.oe_n));
          if (e.a_chk) chk("sram_addr", 32'(sram_addr), 32'(e.addr));
          if (e.d_chk) chk("sram_wdata", 32'(sram_wdata), 32'(e.wdata));
          if (e.r_chk) chk("rd_data", rd_data, e.rd);
        end
      end
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_wdata", 32'(sram_wdata), 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Reset asserted in the middle of a store's low phase
    MEM_W_EN = 1'b1; ALU_result = 32'h408; Val_Rm = 32'hDEADBEEF;
    @(posedge clk) #1;
    chk("mid_lo_we_n", 32'(sram_we_n), 32'h0);
    chk("mid_lo_addr", 32'(sram_addr), 32'h4);
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'h1);
    chk("abort_addr", 32'(sram_addr), 32'h0);
    MEM_W_EN = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'h1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    chk_en = 1'b1;

    // Store: ready low for 7 cycles, high for the DONE cycle
    start_access(1'b0, 1'b1, 32'h408, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("st_ready_seq", 32'(ready), (i < 7) ? 32'h0 : 32'h1);
      if (i < 7) @(posedge clk) #1;
    end
    idle(2);
    chk("sram_4", 32'(sram[4]), 32'hBEEF);
    chk("sram_5", 32'(sram[5]), 32'hDEAD);

    // Load back
    start_access(1'b1, 1'b0, 32'h408, 32'h0);
    wait_done();
    chk("ld_rd", rd_data, 32'hDEADBEEF);
    idle(2);

    // Both enables: store wins, rd_data untouched
    start_access(1'b1, 1'b1, 32'h40C, 32'h12345678);
    wait_done();
    chk("both_rd", rd_data, 32'hDEADBEEF);
    idle(1);
    chk("sram_6", 32'(sram[6]), 32'h5678);
    chk("sram_7", 32'(sram[7]), 32'h1234);

    // Back-to-back: load presented during DONE of a store
    start_access(1'b0, 1'b1, 32'h500, 32'hA5A55A5A);
    wait_done();
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk) #1;
    chk("b2b_idle_ready", 32'(ready), 32'h0);
    start_access(1'b1, 1'b0, 32'h500, 32'h0);
    wait_done();
    chk("b2b_rd", rd_data, 32'hA5A55A5A);
    idle(2);

    // Address below MEM_BASE wraps to the top of the SRAM
    start_access(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D);
    @(posedge clk) #1;
    chk("wrap_lo_addr", 32'(sram_addr), 32'h3FFFE);
    repeat (W) @(posedge clk) #1;
    chk("wrap_hi_addr", 32'(sram_addr), 32'h3FFFF);
    repeat (W) @(posedge clk) #1;
    idle(1);
    chk("sram_wrap_lo", 32'(sram[18'h3FFFE]), 32'hF00D);
    start_access(1'b1, 1'b0, 32'h3FC, 32'h0);
    wait_done();
    chk("wrap_rd", rd_data, 32'hCAFEF00D);
    idle(1);

    start_access(1'b1, 1'b0, 32'h408, 32'h0);
    wait_done();
    chk("reload_rd", rd_data, 32'hDEADBEEF);
    idle(3);
    chk("sched_drained", 32'(sched.size()), 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
